chunked_seq_adder: RTL and testbench



---
 rtl/chunked_seq_adder_pkg.sv | 23 ++
 rtl/chunked_seq_adder_if.sv | 31 +++
 rtl/chunked_seq_adder_chunk_adder.sv | 29 ++
 rtl/chunked_seq_adder.sv | 114 +++++++++++
 tb/tb_chunked_seq_adder.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/chunked_seq_adder_pkg.sv
// Purpose : shared types and sizing helpers for the chunked sequential adder.
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: FSM state encoding, chunk count and counter width computations.
package chunked_seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  // Number of CHUNK-bit slices that make up one WIDTH-bit operand.
  function automatic int calcNChunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk counter width; a single-chunk build still gets a 1-bit counter.
  function automatic int calcCntWidth(input int nChunk);
    return (nChunk <= 1) ? 1 : $clog2(nChunk);
  endfunction

endpackage

// File: rtl/chunked_seq_adder_if.sv
// Purpose : operand/result handshake bundle for the chunked sequential adder.
// Latency : n/a (wires only).
// Backpressure: inValid/inReady on the operand side, outValid/outReady on the result side.
// Ports   : master = producer/consumer side, slave = adder side.
interface chunked_seq_adder_if #(
  parameter int WIDTH = 16
) ();

  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cIn;
  logic             sub;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] sum;
  logic             cOut;
  logic             overflow;

  modport master (
    output inValid, a, b, cIn, sub, outReady,
    input  inReady, outValid, sum, cOut, overflow
  );

  modport slave (
    input  inValid, a, b, cIn, sub, outReady,
    output inReady, outValid, sum, cOut, overflow
  );

endinterface

// File: rtl/chunked_seq_adder_chunk_adder.sv
// Purpose : combinational CHUNK-bit ripple-carry adder slice.
// Latency : 0 cycles (purely combinational).
// Backpressure: none; no handshake.
// Ports   : a, b, cIn -> sum, cOut.
module chunked_seq_adder_chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cIn,
  output logic [CHUNK-1:0] sum,
  output logic             cOut
);

  logic [CHUNK:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cIn;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cOut = carry[CHUNK];

endmodule

// File: rtl/chunked_seq_adder.sv
// Purpose : WIDTH-bit add/subtract done CHUNK bits per clock, LSB chunk first.
// Latency : outValid rises NCHUNK+1 edges after the accepting edge (inclusive).
// Backpressure: one operation in flight; inReady only in IDLE, result held in DONE until outReady.
// Ports   : Clk, Rst (sync, active-high), bus (slave side of chunked_seq_adder_if).
module chunked_seq_adder
  import chunked_seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                 Clk,
  input logic                 Rst,
  chunked_seq_adder_if.slave  bus
);

  localparam int NCHUNK = calcNChunk(WIDTH, CHUNK);
  localparam int CW     = calcCntWidth(NCHUNK);
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  stateT            state;
  stateT            stateNext;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bEffReg;
  logic             carryReg;
  logic [WIDTH-1:0] sumReg;
  logic             cOutReg;
  logic             ovfReg;

  logic [CHUNK-1:0] aChunk;
  logic [CHUNK-1:0] bChunk;
  logic [CHUNK-1:0] chunkSum;
  logic             chunkCout;
  logic             lastChunk;

  assign lastChunk = (cnt == LAST_CNT);
  assign aChunk    = aReg[int'(cnt) * CHUNK +: CHUNK];
  assign bChunk    = bEffReg[int'(cnt) * CHUNK +: CHUNK];

  // One slice adder, reused on every RUN cycle with the carry fed back.
  chunked_seq_adder_chunk_adder #(
    .CHUNK (CHUNK)
  ) uChunk (
    .a    (aChunk),
    .b    (bChunk),
    .cIn  (carryReg),
    .sum  (chunkSum),
    .cOut (chunkCout)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.inValid)  stateNext = RUN;
      RUN:     if (lastChunk)    stateNext = DONE;
      DONE:    if (bus.outReady) stateNext = IDLE;
      default:                   stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt      <= '0;
      aReg     <= '0;
      bEffReg  <= '0;
      carryReg <= 1'b0;
      sumReg   <= '0;
      cOutReg  <= 1'b0;
      ovfReg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inValid) begin
            // Subtract is a + ~b + 1: invert b once here, seed the carry with 1.
            aReg     <= bus.a;
            bEffReg  <= bus.sub ? ~bus.b : bus.b;
            carryReg <= bus.sub ? 1'b1 : bus.cIn;
            sumReg   <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          sumReg[int'(cnt) * CHUNK +: CHUNK] <= chunkSum;
          carryReg <= chunkCout;
          if (lastChunk) begin
            cOutReg <= chunkCout;
            // Top bit of the last chunk is the result MSB.
            ovfReg  <= (aReg[WIDTH-1] == bEffReg[WIDTH-1]) &&
                       (chunkSum[CHUNK-1] != aReg[WIDTH-1]);
            cnt     <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.inReady  = (state == IDLE);
  assign bus.outValid = (state == DONE);
  assign bus.sum      = sumReg;
  assign bus.cOut     = cOutReg;
  assign bus.overflow = ovfReg;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Purpose : directed self-checking bench for chunked_seq_adder at WIDTH=16, CHUNK=4.
// Latency : expects outValid 5 edges after the accepting edge.
// Backpressure: exercises outReady held low in DONE and inValid held during DONE.
module tb_chunked_seq_adder;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  chunked_seq_adder_if #(.WIDTH(16)) bus ();

  chunked_seq_adder #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after the accepting posedge. Drops inValid, waits for the
  // result with a bounded loop, checks latency and result, then retires it.
  task automatic waitResult(input string tag, input logic [15:0] expSum,
                            input logic expCout, input logic expOvf);
    int edges;
    edges = 1;
    @(negedge Clk);
    bus.inValid = 1'b0;
    while (!bus.outValid && edges < 20) begin
      if (bus.inReady !== 1'b0) checkVal({tag, "_inReadyRun"}, 32'(bus.inReady), 32'd0);
      @(posedge Clk);
      edges++;
      @(negedge Clk);
    end
    checkVal({tag, "_latency"}, 32'(edges), 32'd5);
    checkVal({tag, "_sum"}, 32'(bus.sum), 32'(expSum));
    checkVal({tag, "_cOut"}, 32'(bus.cOut), 32'(expCout));
    checkVal({tag, "_ovf"}, 32'(bus.overflow), 32'(expOvf));
    checkVal({tag, "_inReadyDone"}, 32'(bus.inReady), 32'd0);
    bus.outReady = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.outReady = 1'b0;
    checkVal({tag, "_retired"}, 32'(bus.outValid), 32'd0);
  endtask

  task automatic present(input logic [15:0] ta, input logic [15:0] tb2,
                         input logic tc, input logic ts);
    bus.a       = ta;
    bus.b       = tb2;
    bus.cIn     = tc;
    bus.sub     = ts;
    bus.inValid = 1'b1;
  endtask

  task automatic runOp(input string tag, input logic [15:0] ta, input logic [15:0] tb2,
                       input logic tc, input logic ts, input logic [15:0] expSum,
                       input logic expCout, input logic expOvf);
    @(negedge Clk);
    checkVal({tag, "_inReady"}, 32'(bus.inReady), 32'd1);
    present(ta, tb2, tc, ts);
    @(posedge Clk);
    waitResult(tag, expSum, expCout, expOvf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.inValid  = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cIn      = 1'b0;
    bus.sub      = 1'b0;
    bus.outReady = 1'b0;

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    checkVal("rst_inReady", 32'(bus.inReady), 32'd1);
    checkVal("rst_outValid", 32'(bus.outValid), 32'd0);
    checkVal("rst_sum", 32'(bus.sum), 32'd0);
    checkVal("rst_cOut", 32'(bus.cOut), 32'd0);
    checkVal("rst_ovf", 32'(bus.overflow), 32'd0);

    runOp("lat",     16'h0001, 16'h0100, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b0);
    runOp("maxAdd",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    runOp("posOvf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    runOp("borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    runOp("subOvf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Reset two RUN edges in: partial sum 0x00FF and the previous
    // cOut/overflow of 1 must all be cleared.
    @(negedge Clk);
    present(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    bus.inValid = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkVal("midRst_partial", 32'(bus.sum), 32'h00FF);
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    checkVal("midRst_outValid", 32'(bus.outValid), 32'd0);
    checkVal("midRst_inReady", 32'(bus.inReady), 32'd1);
    checkVal("midRst_sum", 32'(bus.sum), 32'd0);
    checkVal("midRst_cOut", 32'(bus.cOut), 32'd0);
    checkVal("midRst_ovf", 32'(bus.overflow), 32'd0);
    runOp("postRst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Backpressure: hold the result while a new pair waits on inValid.
    @(negedge Clk);
    present(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    bus.inValid = 1'b0;
    for (int i = 0; i < 20 && !bus.outValid; i++) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    present(16'h4000, 16'h0005, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkVal("bp_outValid", 32'(bus.outValid), 32'd1);
      checkVal("bp_inReady", 32'(bus.inReady), 32'd0);
      checkVal("bp_sum", 32'(bus.sum), 32'h2345);
      @(posedge Clk);
      @(negedge Clk);
    end
    checkVal("bp_sumHeld", 32'(bus.sum), 32'h2345);
    bus.outReady = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus.outReady = 1'b0;
    checkVal("bp_idle_inReady", 32'(bus.inReady), 32'd1);
    checkVal("bp_idle_outValid", 32'(bus.outValid), 32'd0);
    checkVal("bp_idle_sumKept", 32'(bus.sum), 32'h2345);
    // inValid is still high with the waiting pair: this edge accepts it.
    @(posedge Clk);
    waitResult("bpNext", 16'h4005, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
